// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared state type and default width for seq_divider_16
package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - combinational WIDTH+1-bit trial subtractor with borrow out
module div_trial_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] difference,
  output logic           borrow
);

  // One extra bit on top captures the borrow of the unsigned subtraction.
  logic [WIDTH+1:0] full_diff;

  assign full_diff  = {1'b0, minuend} - {1'b0, subtrahend};
  assign difference = full_diff[WIDTH:0];
  assign borrow     = full_diff[WIDTH+1];

endmodule

// File: rtl/seq_divider_16.sv
// rtl/seq_divider_16.sv - sequential restoring divider, optional SEQ_DIV_ZERO_CHECK_EN shortcut
module seq_divider_16
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             zero_shortcut;
  logic             last_iter;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;

  // A start is honoured in IDLE and DONE; RUN ignores it so operands stay put.
  assign accept    = start && (state != RUN);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef SEQ_DIV_ZERO_CHECK_EN
  assign zero_shortcut = (divisor == '0);
`else
  assign zero_shortcut = 1'b0;
`endif

  // Shifted partial remainder pulls in the next dividend bit from the quotient register.
  assign trial_a = {rem_q, quo_q[WIDTH-1]};
  assign trial_b = {1'b0, dvsr_q};

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_trial (
    .minuend    (trial_a),
    .subtrahend (trial_b),
    .difference (trial_diff),
    .borrow     (trial_borrow)
  );

  // State register; reset acts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_shortcut ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = zero_shortcut ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, one restoring step per RUN cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      dvsr_q <= divisor;
      cnt_q  <= '0;
      if (zero_shortcut) begin
        quo_q <= '1;
        rem_q <= dividend;
      end else begin
        quo_q <= dividend;
        rem_q <= '0;
      end
    end else if (state == RUN) begin
      cnt_q <= cnt_q + CW'(1);
      quo_q <= {quo_q[WIDTH-2:0], ~trial_borrow};
      rem_q <= trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    end
  end

`ifdef SEQ_DIV_ZERO_CHECK_EN
  logic dz_q;

  // Divide-by-zero flag follows each accepted request and holds until the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_q <= 1'b0;
    end else if (accept) begin
      dz_q <= zero_shortcut;
    end
  end

  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider_16.sv
// tb/tb_seq_divider_16.sv - directed self-checking bench for seq_divider_16
module tb_seq_divider_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int passed = 0;
  int total = 0;
  int lat;

  seq_divider_16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Present a request and step past its accepting edge; caller is then at latency 1.
  task automatic start_op(input logic [15:0] dd, input logic [15:0] dv);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count accepting-edge-inclusive edges until done, bounded.
  task automatic wait_done(input int base, output int l);
    l = base;
    while (!done && l < 60) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (quotient !== 16'd0) $display("FAIL reset_quo got %0d want 0", quotient); else passed++;
    total++; if (remainder !== 16'd0) $display("FAIL reset_rem got %0d want 0", remainder); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_zero); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    start_op(16'd100, 16'd7);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
    wait_done(1, lat);
    total++; if (lat !== 17) $display("FAIL basic_latency got %0d want 17", lat); else passed++;
    total++; if (quotient !== 16'd14) $display("FAIL basic_quo got %0d want 14", quotient); else passed++;
    total++; if (remainder !== 16'd2) $display("FAIL basic_rem got %0d want 2", remainder); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL basic_dz got %b want 0", div_zero); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_done got %b want 0", busy); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (done !== 1'b0) $display("FAIL hold_done got %b want 0", done); else passed++;
    total++; if (quotient !== 16'd14) $display("FAIL hold_quo got %0d want 14", quotient); else passed++;
    total++; if (remainder !== 16'd2) $display("FAIL hold_rem got %0d want 2", remainder); else passed++;
  endtask

  task automatic test_vectors;
    start_op(16'd65535, 16'd1);
    wait_done(1, lat);
    total++; if (quotient !== 16'd65535) $display("FAIL max_quo got %0d want 65535", quotient); else passed++;
    total++; if (remainder !== 16'd0) $display("FAIL max_rem got %0d want 0", remainder); else passed++;
    start_op(16'd5, 16'd9);
    wait_done(1, lat);
    total++; if (quotient !== 16'd0) $display("FAIL small_quo got %0d want 0", quotient); else passed++;
    total++; if (remainder !== 16'd5) $display("FAIL small_rem got %0d want 5", remainder); else passed++;
    start_op(16'd0, 16'd5);
    wait_done(1, lat);
    total++; if (lat !== 17) $display("FAIL zero_dd_latency got %0d want 17", lat); else passed++;
    total++; if (quotient !== 16'd0) $display("FAIL zero_dd_quo got %0d want 0", quotient); else passed++;
    total++; if (remainder !== 16'd0) $display("FAIL zero_dd_rem got %0d want 0", remainder); else passed++;
  endtask

  task automatic test_div_zero;
    int   exp_lat;
    logic exp_dz;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    exp_lat = 1;
    exp_dz  = 1'b1;
`else
    exp_lat = 17;
    exp_dz  = 1'b0;
`endif
    start_op(16'd1234, 16'd0);
    wait_done(1, lat);
    total++; if (lat !== exp_lat) $display("FAIL dz_latency got %0d want %0d", lat, exp_lat); else passed++;
    total++; if (div_zero !== exp_dz) $display("FAIL dz_flag got %b want %b", div_zero, exp_dz); else passed++;
    total++; if (quotient !== 16'hFFFF) $display("FAIL dz_quo got %h want ffff", quotient); else passed++;
    total++; if (remainder !== 16'd1234) $display("FAIL dz_rem got %0d want 1234", remainder); else passed++;
  endtask

  task automatic test_ignore_busy;
    start_op(16'd200, 16'd3);
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 16'd9000;
    divisor  = 16'd11;
    total++; if (busy !== 1'b1) $display("FAIL ign_busy got %b want 1", busy); else passed++;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, lat);
    total++; if (lat !== 17) $display("FAIL ign_latency got %0d want 17", lat); else passed++;
    total++; if (quotient !== 16'd66) $display("FAIL ign_quo got %0d want 66", quotient); else passed++;
    total++; if (remainder !== 16'd2) $display("FAIL ign_rem got %0d want 2", remainder); else passed++;
  endtask

  task automatic test_reset_midrun;
    start_op(16'd20000, 16'd2000);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mid_rst_done got %b want 0", done); else passed++;
    total++; if (quotient !== 16'd0) $display("FAIL mid_rst_quo got %0d want 0", quotient); else passed++;
    total++; if (remainder !== 16'd0) $display("FAIL mid_rst_rem got %0d want 0", remainder); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_op(16'd26, 16'd2);
    total++; if (busy !== 1'b1) $display("FAIL post_rst_busy got %b want 1", busy); else passed++;
    wait_done(1, lat);
    total++; if (lat !== 17) $display("FAIL post_rst_latency got %0d want 17", lat); else passed++;
    total++; if (quotient !== 16'd13) $display("FAIL post_rst_quo got %0d want 13", quotient); else passed++;
    total++; if (remainder !== 16'd0) $display("FAIL post_rst_rem got %0d want 0", remainder); else passed++;
  endtask

  task automatic test_back_to_back;
    start_op(16'd1000, 16'd200);
    wait_done(1, lat);
    total++; if (quotient !== 16'd5) $display("FAIL b2b_first_quo got %0d want 5", quotient); else passed++;
    total++; if (remainder !== 16'd0) $display("FAIL b2b_first_rem got %0d want 0", remainder); else passed++;
    start_op(16'd89, 16'd11);
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL b2b_done got %b want 0", done); else passed++;
    wait_done(1, lat);
    total++; if (lat !== 17) $display("FAIL b2b_latency got %0d want 17", lat); else passed++;
    total++; if (quotient !== 16'd8) $display("FAIL b2b_quo got %0d want 8", quotient); else passed++;
    total++; if (remainder !== 16'd1) $display("FAIL b2b_rem got %0d want 1", remainder); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_busy();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
